// File: rtl/gpr_wb_arbiter.sv
// GPR write-port arbiter at the end of writeback.
// Merges in-order pipeline results (priority) with long-latency unit results
// (valid/ready, buffered in a small FIFO). A starvation counter stalls the pipeline
// so buffered results always drain. Writes to x0 are consumed but never issued.
// Optional: define GPR_WB_SCOREBOARD_EN to add the pending-destination scoreboard
// (issue_valid/issue_addr inputs, pend_vec output).
module gpr_wb_arbiter #(
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned ADDR_W       = 5,
  parameter int unsigned FIFO_DEPTH   = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          pipe_we_,
  input  logic [ADDR_W-1:0]             pipe_addr,
  input  logic [DATA_W-1:0]             pipe_data,
  output logic                          pipe_stall,
  input  logic                          lu_valid,
  output logic                          lu_ready,
  input  logic [ADDR_W-1:0]             lu_addr,
  input  logic [DATA_W-1:0]             lu_data,
  output logic                          we_,
  output logic [ADDR_W-1:0]             wr_addr,
  output logic [DATA_W-1:0]             wr_data,
`ifdef GPR_WB_SCOREBOARD_EN
  input  logic                          issue_valid,
  input  logic [ADDR_W-1:0]             issue_addr,
  output logic [31:0]                   pend_vec,
`endif
  output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned SC_W  = $clog2(STARVE_LIMIT + 1);

  logic [ADDR_W-1:0] mem_addr [FIFO_DEPTH];
  logic [DATA_W-1:0] mem_data [FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_ptr, wr_ptr;
  logic [PTR_W:0]    cnt;
  logic [SC_W-1:0]   starve_cnt;

  logic              fifo_empty, fifo_full, starve_hit, lu_xfer;
  logic              sel_valid, pop, bypass, push;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;

  logic              we_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [DATA_W-1:0] wr_data_q;

  // Handshake and stall flags, all derived from registered state.
  always_comb begin
    fifo_empty = (cnt == '0);
    fifo_full  = (cnt == (PTR_W + 1)'(FIFO_DEPTH));
    starve_hit = !fifo_empty && (starve_cnt == SC_W'(STARVE_LIMIT));
    pipe_stall = !reset && starve_hit;
    lu_ready   = !reset && !fifo_full;
    lu_xfer    = lu_valid && lu_ready;
  end

  // Priority select: starved FIFO head, pipeline, FIFO head, lu bypass.
  always_comb begin
    sel_valid = 1'b0;
    sel_addr  = '0;
    sel_data  = '0;
    pop       = 1'b0;
    bypass    = 1'b0;
    if (starve_hit) begin
      sel_valid = 1'b1;
      pop       = 1'b1;
      sel_addr  = mem_addr[rd_ptr];
      sel_data  = mem_data[rd_ptr];
    end else if (!pipe_we_) begin
      sel_valid = 1'b1;
      sel_addr  = pipe_addr;
      sel_data  = pipe_data;
    end else if (!fifo_empty) begin
      sel_valid = 1'b1;
      pop       = 1'b1;
      sel_addr  = mem_addr[rd_ptr];
      sel_data  = mem_data[rd_ptr];
    end else if (lu_xfer) begin
      sel_valid = 1'b1;
      bypass    = 1'b1;
      sel_addr  = lu_addr;
      sel_data  = lu_data;
    end
    push = lu_xfer && !bypass;
  end

  // FIFO storage; contents need no reset since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_addr[wr_ptr] <= lu_addr;
      mem_data[wr_ptr] <= lu_data;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at a power-of-2 depth.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      cnt <= cnt + 1'b1;
      else if (pop && !push) cnt <= cnt - 1'b1;
    end
  end

  // Starvation counter: counts cycles a non-empty FIFO goes without a pop.
  always_ff @(posedge clk) begin
    if (reset || fifo_empty || pop) begin
      starve_cnt <= '0;
    end else if (starve_cnt != SC_W'(STARVE_LIMIT)) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  // Registered GPR write port; x0 writes are swallowed here.
  always_ff @(posedge clk) begin
    if (reset) begin
      we_q      <= 1'b1;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else if (sel_valid) begin
      if (sel_addr == '0) begin
        we_q      <= 1'b1;
        wr_addr_q <= '0;
      end else begin
        we_q      <= 1'b0;
        wr_addr_q <= sel_addr;
        wr_data_q <= sel_data;
      end
    end else begin
      we_q <= 1'b1;
    end
  end

  assign we_      = we_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign fifo_cnt = cnt;

`ifdef GPR_WB_SCOREBOARD_EN
  logic [31:0] pend_q, set_mask, clr_mask;

  // Pending-destination masks; a new issue beats a same-cycle retire.
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (issue_valid && (issue_addr != '0)) set_mask = 32'(1) << issue_addr;
    if (pop || bypass)                     clr_mask = 32'(1) << sel_addr;
  end

  // Pending-destination register; bit 0 is never pending.
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_q <= '0;
    end else begin
      pend_q <= ((pend_q & ~clr_mask) | set_mask) & ~32'(1);
    end
  end

  assign pend_vec = pend_q;
`endif

endmodule

// File: tb/tb_gpr_wb_arbiter.sv
// Self-checking bench for gpr_wb_arbiter: directed scenarios then random traffic,
// all compared against a queue-based behavioural model of the arbitration rules.
module tb_gpr_wb_arbiter;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int DEPTH = 2;
  localparam int LIMIT = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          pipe_we_;
  logic [AW-1:0] pipe_addr;
  logic [DW-1:0] pipe_data;
  logic          pipe_stall;
  logic          lu_valid;
  logic          lu_ready;
  logic [AW-1:0] lu_addr;
  logic [DW-1:0] lu_data;
  logic          we_;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [$clog2(DEPTH):0] fifo_cnt;
`ifdef GPR_WB_SCOREBOARD_EN
  logic          issue_valid;
  logic [AW-1:0] issue_addr;
  logic [31:0]   pend_vec;
  logic [31:0]   exp_pend;
`endif

  gpr_wb_arbiter #(
    .DATA_W(DW), .ADDR_W(AW), .FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .pipe_we_   (pipe_we_),
    .pipe_addr  (pipe_addr),
    .pipe_data  (pipe_data),
    .pipe_stall (pipe_stall),
    .lu_valid   (lu_valid),
    .lu_ready   (lu_ready),
    .lu_addr    (lu_addr),
    .lu_data    (lu_data),
    .we_        (we_),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
`ifdef GPR_WB_SCOREBOARD_EN
    .issue_valid(issue_valid),
    .issue_addr (issue_addr),
    .pend_vec   (pend_vec),
`endif
    .fifo_cnt   (fifo_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } ent_t;

  // Reference model state: buffered results in arrival order, wait count, expected port.
  ent_t          q[$];
  int            starve;
  logic          exp_we;
  logic [AW-1:0] exp_addr;
  logic [DW-1:0] exp_data;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    starve   = 0;
    exp_we   = 1'b1;
    exp_addr = '0;
    exp_data = '0;
`ifdef GPR_WB_SCOREBOARD_EN
    exp_pend = '0;
`endif
  endtask

  function automatic logic model_stall();
    return (q.size() != 0) && (starve == LIMIT);
  endfunction

  function automatic logic model_ready();
    return q.size() < DEPTH;
  endfunction

  // One clock cycle: drive inputs, compare all outputs, advance the model.
  task automatic step(input logic pwe, input logic [AW-1:0] pa, input logic [DW-1:0] pd,
                      input logic lv, input logic [AW-1:0] la, input logic [DW-1:0] ld,
                      input logic iv, input logic [AW-1:0] ia);
    logic          st, rdy, xfer, got, from_lu, byp;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    ent_t          e;
    int            n0;
    @(negedge clk);
    reset     = 1'b0;
    pipe_we_  = pwe;
    pipe_addr = pa;
    pipe_data = pd;
    lu_valid  = lv;
    lu_addr   = la;
    lu_data   = ld;
`ifdef GPR_WB_SCOREBOARD_EN
    issue_valid = iv;
    issue_addr  = ia;
`endif
    #1;
    st  = model_stall();
    rdy = model_ready();
    check("pipe_stall", 64'(pipe_stall), 64'(st));
    check("lu_ready", 64'(lu_ready), 64'(rdy));
    check("we_", 64'(we_), 64'(exp_we));
    check("wr_addr", 64'(wr_addr), 64'(exp_addr));
    check("wr_data", 64'(wr_data), 64'(exp_data));
    check("fifo_cnt", 64'(fifo_cnt), 64'(q.size()));
`ifdef GPR_WB_SCOREBOARD_EN
    check("pend_vec", 64'(pend_vec), 64'(exp_pend));
`endif
    n0      = q.size();
    xfer    = lv && rdy;
    got     = 1'b0;
    from_lu = 1'b0;
    byp     = 1'b0;
    wa      = '0;
    wd      = '0;
    if (st || (pwe && n0 != 0)) begin
      e = q.pop_front();
      got = 1'b1; from_lu = 1'b1; wa = e.a; wd = e.d;
    end else if (!pwe) begin
      got = 1'b1; wa = pa; wd = pd;
    end else if (xfer) begin
      got = 1'b1; from_lu = 1'b1; byp = 1'b1; wa = la; wd = ld;
    end
    if (xfer && !byp) q.push_back('{a: la, d: ld});
    if (n0 == 0 || (from_lu && !byp)) starve = 0;
    else if (starve < LIMIT) starve++;
    if (got && wa != 0) begin
      exp_we = 1'b0; exp_addr = wa; exp_data = wd;
    end else begin
      exp_we = 1'b1;
      if (got) exp_addr = '0;
    end
`ifdef GPR_WB_SCOREBOARD_EN
    if (from_lu) exp_pend[wa] = 1'b0;
    if (iv && ia != 0) exp_pend[ia] = 1'b1;
    exp_pend[0] = 1'b0;
`endif
  endtask

  task automatic idle();
    step(1'b1, '0, '0, 1'b0, '0, '0, 1'b0, '0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset    = 1'b1;
    pipe_we_ = 1'b1;
    lu_valid = 1'b0;
`ifdef GPR_WB_SCOREBOARD_EN
    issue_valid = 1'b0;
`endif
    #1;
    check("rst_lu_ready", 64'(lu_ready), 64'd0);
    check("rst_pipe_stall", 64'(pipe_stall), 64'd0);
    @(posedge clk);
    #1;
    check("rst_fifo_cnt", 64'(fifo_cnt), 64'd0);
    check("rst_we_", 64'(we_), 64'd1);
    model_reset();
  endtask

  initial begin
    logic          pwe, lv, iv;
    logic [AW-1:0] pa, la, ia;
    logic [DW-1:0] pd, ld;
    reset = 1'b1; pipe_we_ = 1'b1; pipe_addr = '0; pipe_data = '0;
    lu_valid = 1'b0; lu_addr = '0; lu_data = '0;
`ifdef GPR_WB_SCOREBOARD_EN
    issue_valid = 1'b0; issue_addr = '0;
`endif
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("init_we_", 64'(we_), 64'd1);
    check("init_wr_addr", 64'(wr_addr), 64'd0);
    check("init_wr_data", 64'(wr_data), 64'd0);
    check("init_fifo_cnt", 64'(fifo_cnt), 64'd0);
    check("init_lu_ready", 64'(lu_ready), 64'd0);

    // Pipe only.
    step(1'b0, 5'd5, 32'h1234, 1'b0, '0, '0, 1'b0, '0);
    idle();
    check("pipe_we_", 64'(we_), 64'd0);
    check("pipe_wr_addr", 64'(wr_addr), 64'd5);
    check("pipe_wr_data", 64'(wr_data), 64'h1234);
    idle();
    check("pipe_we_idle", 64'(we_), 64'd1);

    // Bypass.
    step(1'b1, '0, '0, 1'b1, 5'd7, 32'hAA, 1'b0, '0);
    idle();
    check("byp_wr_addr", 64'(wr_addr), 64'd7);
    check("byp_wr_data", 64'(wr_data), 64'hAA);
    check("byp_fifo_cnt", 64'(fifo_cnt), 64'd0);

    // Conflict: continuous pipe writes, two lu results queued and drained by starvation.
    step(1'b0, 5'd10, 32'h55, 1'b1, 5'd3, 32'h333, 1'b0, '0);
    step(1'b0, 5'd10, 32'h55, 1'b1, 5'd4, 32'h444, 1'b0, '0);
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 5'd10, 32'h55, 1'b0, '0, '0, 1'b0, '0);
      if (i == 0) begin
        check("cf_fifo_cnt", 64'(fifo_cnt), 64'd2);
        check("cf_lu_ready", 64'(lu_ready), 64'd0);
      end
      check("cf_stall_seq", 64'(pipe_stall), 64'((i == 3) || (i == 8)));
      if (i == 4) check("cf_reg3", 64'(wr_addr), 64'd3);
      if (i == 9) check("cf_reg4", 64'(wr_addr), 64'd4);
    end
    idle();
    idle();

    // x0 suppression from pipe and from lu.
    step(1'b0, 5'd0, 32'hFFFF, 1'b0, '0, '0, 1'b0, '0);
    idle();
    check("x0_pipe_we_", 64'(we_), 64'd1);
    check("x0_pipe_addr", 64'(wr_addr), 64'd0);
    step(1'b1, '0, '0, 1'b1, 5'd0, 32'hBEEF, 1'b0, '0);
    idle();
    check("x0_lu_we_", 64'(we_), 64'd1);
    check("x0_lu_fifo_cnt", 64'(fifo_cnt), 64'd0);

    // Reset mid-operation with two queued entries.
    step(1'b0, 5'd11, 32'h1, 1'b1, 5'd12, 32'hC0, 1'b0, '0);
    step(1'b0, 5'd11, 32'h2, 1'b1, 5'd13, 32'hD0, 1'b0, '0);
    step(1'b0, 5'd11, 32'h3, 1'b0, '0, '0, 1'b0, '0);
    check("mr_fifo_full", 64'(fifo_cnt), 64'd2);
    do_reset();
    for (int i = 0; i < 8; i++) begin
      idle();
      check("mr_no_write", 64'(we_), 64'd1);
    end

`ifdef GPR_WB_SCOREBOARD_EN
    step(1'b1, '0, '0, 1'b0, '0, '0, 1'b1, 5'd9);
    idle();
    check("sb_set", 64'(pend_vec[9]), 64'd1);
    step(1'b1, '0, '0, 1'b1, 5'd9, 32'h99, 1'b0, '0);
    idle();
    check("sb_clear", 64'(pend_vec[9]), 64'd0);
    step(1'b1, '0, '0, 1'b0, '0, '0, 1'b1, 5'd9);
    step(1'b1, '0, '0, 1'b1, 5'd9, 32'h98, 1'b1, 5'd9);
    idle();
    check("sb_set_wins", 64'(pend_vec[9]), 64'd1);
`endif

    // Random traffic honouring the hold-stable rules of both sources.
    pwe = 1'b1; pa = '0; pd = '0; lv = 1'b0; la = '0; ld = '0;
    for (int i = 0; i < 400; i++) begin
      if (!model_stall()) begin
        pwe = ($urandom_range(0, 1) == 0);
        pa  = AW'($urandom_range(0, 31));
        pd  = $urandom;
      end
      if (!(lv && !model_ready())) begin
        lv = ($urandom_range(0, 1) == 0);
        la = AW'($urandom_range(0, 31));
        ld = $urandom;
      end
      iv = ($urandom_range(0, 3) == 0);
      ia = AW'($urandom_range(0, 31));
      step(pwe, pa, pd, lv, la, ld, iv, ia);
      if (i == 200) do_reset();
    end
    idle();
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
